// File: rtl/decodificador_pt2272.sv
// PT2272-style receiver: oversamples the PT2262 serial stream, decodes 8 ternary address
// and 4 data symbols, and publishes the data nibble after two identical matching frames.
module decodificador_pt2272 #(
    parameter int CLK_PER_ALPHA = 250,
    parameter int SYNC_MIN_A    = 64,
    parameter int LOST_A        = 160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cod_i,
    input  logic [7:0] A_01,
    input  logic [7:0] A_F,
    output logic [3:0] D_o,
    output logic       vt,
    output logic       sync,
    output logic       erro,
    output logic [2:0] o_dbg_state
);

    localparam logic [15:0] SHORT_MIN = 16'(2 * CLK_PER_ALPHA);
    localparam logic [15:0] SHORT_MAX = 16'(7 * CLK_PER_ALPHA);
    localparam logic [15:0] LONG_MIN  = 16'(8 * CLK_PER_ALPHA);
    localparam logic [15:0] LONG_MAX  = 16'(16 * CLK_PER_ALPHA);
    localparam logic [15:0] SYNC_CYC  = 16'(SYNC_MIN_A * CLK_PER_ALPHA);
    localparam logic [15:0] LOST_CYC  = 16'(LOST_A * CLK_PER_ALPHA);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_RX     = 3'd1,
        ST_WAIT_S = 3'd2,
        ST_CHECK  = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Input synchroniser and edge detection
    logic [1:0]  r_meta;
    logic        r_cod_d;
    logic        w_cod;
    logic        w_rise;
    logic        w_fall;

    // Phase width counters
    logic [15:0] r_hi_cnt;
    logic [15:0] r_lo_cnt;
    logic [15:0] w_hi_next;
    logic [15:0] w_lo_next;
    logic        w_sync_ev;
    logic        w_lost;

    // Pulse classification
    logic        w_p0;
    logic        w_p1;
    logic        w_pbad;
    logic        w_prev_bit;

    // Frame assembly and decision
    state_t      r_state;
    logic [4:0]  r_pidx;
    logic        r_first;
    logic [23:0] r_frame;
    logic [1:0]  r_match;
    logic [3:0]  r_prev_data;
    logic [3:0]  r_data_o;
    logic        r_vt;
    logic        r_sync;
    logic        r_erro;
    logic        w_addr_ok;
    logic        w_data_f;
    logic [3:0]  w_data;
    logic        w_same;
    logic [1:0]  w_cnt_new;

    function automatic logic is_short(input logic [15:0] w);
        return (w >= SHORT_MIN) && (w <= SHORT_MAX);
    endfunction

    function automatic logic is_long(input logic [15:0] w);
        return (w >= LONG_MIN) && (w <= LONG_MAX);
    endfunction

    assign w_cod  = r_meta[1];
    assign w_rise = w_cod & ~r_cod_d;
    assign w_fall = ~w_cod & r_cod_d;

    // Counters restart at 1 on the edge that opens their phase, so at the opposite
    // edge they hold the exact width of the phase just finished.
    always_comb begin
        w_hi_next = r_hi_cnt;
        w_lo_next = r_lo_cnt;
        if (w_rise) begin
            w_hi_next = 16'd1;
        end else if (w_cod && (r_hi_cnt != 16'hFFFF)) begin
            w_hi_next = r_hi_cnt + 16'd1;
        end
        if (w_fall) begin
            w_lo_next = 16'd1;
        end else if (!w_cod && (r_lo_cnt != 16'hFFFF)) begin
            w_lo_next = r_lo_cnt + 16'd1;
        end
    end

    assign w_sync_ev = ~w_cod && (w_lo_next == SYNC_CYC) && (w_lo_next != r_lo_cnt);
    assign w_lost    = ~w_cod && (w_lo_next == LOST_CYC) && (w_lo_next != r_lo_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 2'b00;
            r_cod_d  <= 1'b0;
            r_hi_cnt <= 16'd0;
            r_lo_cnt <= 16'd0;
        end else begin
            r_meta   <= {r_meta[0], cod_i};
            r_cod_d  <= w_cod;
            r_hi_cnt <= w_hi_next;
            r_lo_cnt <= w_lo_next;
        end
    end

    // A pulse is judged at the rising edge that follows it: previous high, then its low.
    assign w_p0       = is_short(r_hi_cnt) && is_long(r_lo_cnt);
    assign w_p1       = is_long(r_hi_cnt) && is_short(r_lo_cnt);
    assign w_pbad     = ~(w_p0 | w_p1);
    assign w_prev_bit = r_frame[{r_pidx[4:1], 1'b0}];

    // Symbols are pulse pairs {first, second}: 00 = '0', 11 = '1', 01 = 'F'.
    // The illegal 10 pair never reaches r_frame.
    always_comb begin
        w_addr_ok = 1'b1;
        w_data_f  = 1'b0;
        w_data    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (A_F[i]) begin
                if (!((r_frame[2*i] == 1'b0) && (r_frame[2*i+1] == 1'b1))) begin
                    w_addr_ok = 1'b0;
                end
            end else if (!((r_frame[2*i] == A_01[i]) && (r_frame[2*i+1] == A_01[i]))) begin
                w_addr_ok = 1'b0;
            end
        end
        for (int j = 0; j < 4; j++) begin
            w_data[j] = r_frame[16+2*j+1];
            if (r_frame[16+2*j] != r_frame[16+2*j+1]) begin
                w_data_f = 1'b1;
            end
        end
    end

    assign w_same    = (w_data == r_prev_data);
    assign w_cnt_new = !w_same ? 2'd1 : ((r_match == 2'd3) ? 2'd3 : r_match + 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_pidx      <= 5'd0;
            r_first     <= 1'b0;
            r_frame     <= 24'd0;
            r_match     <= 2'd0;
            r_prev_data <= 4'd0;
            r_data_o    <= 4'd0;
            r_vt        <= 1'b0;
            r_sync      <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_sync <= w_sync_ev;
            r_erro <= 1'b0;
            if (w_lost) begin
                r_vt    <= 1'b0;
                r_match <= 2'd0;
                r_state <= ST_HUNT;
            end else begin
                unique case (r_state)
                    ST_HUNT: begin
                        if (w_sync_ev) begin
                            r_state <= ST_RX;
                            r_pidx  <= 5'd0;
                            r_first <= 1'b1;
                        end
                    end
                    ST_RX: begin
                        if (w_sync_ev) begin
                            // Gap arrived before the frame was complete: restart on it.
                            r_erro  <= 1'b1;
                            r_match <= 2'd0;
                            r_vt    <= 1'b0;
                            r_pidx  <= 5'd0;
                            r_first <= 1'b1;
                        end else if (w_rise) begin
                            if (r_first) begin
                                // This edge closes the sync gap itself, not a data pulse.
                                r_first <= 1'b0;
                            end else if (w_pbad || (r_pidx[0] && w_prev_bit && !w_p1)) begin
                                r_erro  <= 1'b1;
                                r_state <= ST_ERR;
                            end else begin
                                r_frame[r_pidx] <= w_p1;
                                if (r_pidx == 5'd23) begin
                                    r_state <= ST_WAIT_S;
                                end else begin
                                    r_pidx <= r_pidx + 5'd1;
                                end
                            end
                        end
                    end
                    ST_WAIT_S: begin
                        if (w_sync_ev) begin
                            r_state <= ST_CHECK;
                        end else if ((w_fall && !is_short(r_hi_cnt)) || w_rise) begin
                            r_erro  <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                    ST_CHECK: begin
                        if (!w_addr_ok) begin
                            r_vt    <= 1'b0;
                            r_match <= 2'd0;
                        end else if (w_data_f) begin
                            r_erro  <= 1'b1;
                            r_vt    <= 1'b0;
                            r_match <= 2'd0;
                        end else begin
                            r_match     <= w_cnt_new;
                            r_prev_data <= w_data;
                            if (w_cnt_new >= 2'd2) begin
                                r_data_o <= w_data;
                                r_vt     <= 1'b1;
                            end
                        end
                        r_state <= ST_RX;
                        r_pidx  <= 5'd0;
                        r_first <= 1'b1;
                    end
                    ST_ERR: begin
                        r_vt    <= 1'b0;
                        r_match <= 2'd0;
                        r_state <= ST_HUNT;
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign D_o         = r_data_o;
    assign vt          = r_vt;
    assign sync        = r_sync;
    assign erro        = r_erro;
    assign o_dbg_state = r_state;

endmodule
